// File: rtl/vio_counter_gen_if.sv
// vio_counter_gen_if: VIO probe bundle for vio_counter_gen.
// Controls come from probe_out (master side). count/tc/done return to probe_in.
interface vio_counter_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             up_dn;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             done;

  modport master (
    output en, up_dn, mode, load, load_val,
    input  count, tc, done
  );

  modport slave (
    input  en, up_dn, mode, load, load_val,
    output count, tc, done
  );
endinterface

// File: rtl/vio_counter_gen.sv
// vio_counter_gen: parametrised up/down counter with a prescaler, wrap/saturate/ping-pong
// modes, parallel load and a one-cycle terminal-count pulse.
// Optional macro VIO_COUNTER_LOAD_EDGE_EN: when defined, load is rising-edge detected.
// When it is not defined, load is level-sensitive.
module vio_counter_gen #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 255,
  parameter int unsigned PRESCALE  = 1
) (
  input logic              clk,
  input logic              reset,
  vio_counter_gen_if.slave bus
);

  localparam int unsigned      PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_COUNT);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [1:0]       MODE_SAT = 2'b01;
  localparam logic [1:0]       MODE_PP  = 2'b10;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  dir_e             dir_q, dir_d;
  logic [PW-1:0]    pre_q, pre_d;

  logic             tick_c;
  logic             load_c;
  logic [WIDTH-1:0] load_clamp_c;
  logic [WIDTH-1:0] target_c;
  logic [WIDTH-1:0] step_c;
  logic             pp_up_c;
  logic [WIDTH-1:0] pp_next_c;
  logic             pp_end_c;

`ifdef VIO_COUNTER_LOAD_EDGE_EN
  logic load_q;

  // Registered copy of load for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) load_q <= 1'b0;
    else        load_q <= bus.load;
  end

  assign load_c = bus.load & ~load_q;
`else
  assign load_c = bus.load;
`endif

  // Prescaler terminal cycle gates every count step.
  assign tick_c       = bus.en && (pre_q == PRE_LAST);
  assign load_clamp_c = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
  assign target_c     = bus.up_dn ? MAX_V : '0;
  assign step_c       = bus.up_dn ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));

  // Ping-pong turns around at either endpoint even if dir points outward (e.g. on mode entry).
  assign pp_up_c   = (dir_q == DIR_UP) ? (count_q != MAX_V) : (count_q == '0);
  assign pp_next_c = pp_up_c ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
  assign pp_end_c  = (pp_next_c == MAX_V) || (pp_next_c == '0);

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= DIR_UP;
      pre_q   <= '0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      pre_q   <= pre_d;
    end
  end

  // Next-state: load beats tick, tick beats hold.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    dir_d   = dir_q;
    pre_d   = pre_q;

    if (bus.mode != MODE_PP) dir_d = dir_e'(bus.up_dn);
    if ((bus.mode != MODE_SAT) || (count_q != target_c)) done_d = 1'b0;

    if (load_c) begin
      count_d = load_clamp_c;
      pre_d   = '0;
      done_d  = 1'b0;
      tc_d    = 1'b0;
      if (bus.mode == MODE_PP) dir_d = (load_clamp_c == MAX_V) ? DIR_DOWN : DIR_UP;
    end else if (bus.en) begin
      pre_d = tick_c ? '0 : (pre_q + PW'(1));
      if (tick_c) begin
        case (bus.mode)
          MODE_SAT: begin
            if (count_q == target_c) begin
              done_d = 1'b1;
            end else begin
              count_d = step_c;
              if (step_c == target_c) begin
                tc_d   = 1'b1;
                done_d = 1'b1;
              end
            end
          end
          MODE_PP: begin
            count_d = pp_next_c;
            tc_d    = pp_end_c;
            dir_d   = dir_e'(pp_up_c ^ pp_end_c);
          end
          default: begin
            if (bus.up_dn) begin
              if (count_q >= MAX_V) begin
                count_d = '0;
                tc_d    = 1'b1;
              end else begin
                count_d = count_q + WIDTH'(1);
              end
            end else begin
              if (count_q == '0) begin
                count_d = MAX_V;
                tc_d    = 1'b1;
              end else begin
                count_d = count_q - WIDTH'(1);
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_vio_counter_gen.sv
// tb_vio_counter_gen: directed scoreboard bench for vio_counter_gen.
// Four instances: A wrap 8b/255/1, B 4b/9/3, C 8b/100/1 (saturate/clamp), D 8b/5/1 ping-pong.
module tb_vio_counter_gen;

  logic clk;
  logic rst_n;

  vio_counter_gen_if #(.WIDTH(8)) if_a ();
  vio_counter_gen_if #(.WIDTH(4)) if_b ();
  vio_counter_gen_if #(.WIDTH(8)) if_c ();
  vio_counter_gen_if #(.WIDTH(8)) if_d ();

  vio_counter_gen #(.WIDTH(8), .MAX_COUNT(255), .PRESCALE(1)) u_a (.clk(clk), .reset(rst_n), .bus(if_a));
  vio_counter_gen #(.WIDTH(4), .MAX_COUNT(9),   .PRESCALE(3)) u_b (.clk(clk), .reset(rst_n), .bus(if_b));
  vio_counter_gen #(.WIDTH(8), .MAX_COUNT(100), .PRESCALE(1)) u_c (.clk(clk), .reset(rst_n), .bus(if_c));
  vio_counter_gen #(.WIDTH(8), .MAX_COUNT(5),   .PRESCALE(1)) u_d (.clk(clk), .reset(rst_n), .bus(if_d));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         dut;
    string      tag;
    logic [7:0] count;
    logic       tc;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int d, input string tag, input int c, input bit t, input bit dn);
    exp_t e;
    e.dut   = d;
    e.tag   = tag;
    e.count = 8'(c);
    e.tc    = t;
    e.done  = dn;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t       e;
    logic [7:0] oc;
    logic       ot;
    logic       od;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        oc = if_a.count; ot = if_a.tc; od = if_a.done;
      end else if (e.dut == 1) begin
        oc = {4'b0000, if_b.count}; ot = if_b.tc; od = if_b.done;
      end else if (e.dut == 2) begin
        oc = if_c.count; ot = if_c.tc; od = if_c.done;
      end else begin
        oc = if_d.count; ot = if_d.tc; od = if_d.done;
      end
      chk({e.tag, "_count"}, oc, e.count);
      chk({e.tag, "_tc"}, {7'b0, ot}, {7'b0, e.tc});
      chk({e.tag, "_done"}, {7'b0, od}, {7'b0, e.done});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int e_b;
    int s_b;
    int pos;
    bit en_b;

    rst_n = 1'b0;
    if_a.en = 1'b1; if_a.up_dn = 1'b1; if_a.mode = 2'b00; if_a.load = 1'b0; if_a.load_val = 8'd0;
    if_b.en = 1'b1; if_b.up_dn = 1'b0; if_b.mode = 2'b00; if_b.load = 1'b0; if_b.load_val = 4'd0;
    if_c.en = 1'b0; if_c.up_dn = 1'b1; if_c.mode = 2'b01; if_c.load = 1'b0; if_c.load_val = 8'd0;
    if_d.en = 1'b1; if_d.up_dn = 1'b1; if_d.mode = 2'b10; if_d.load = 1'b0; if_d.load_val = 8'd0;

    // Reset values on all instances.
    for (int d = 0; d < 4; d++) push(d, "reset", 0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    // A free-runs wrap-up; B wrap-down /3 with an en gap; D ping-pong with up_dn toggling.
    e_b = 0;
    for (int k = 1; k <= 260; k++) begin
      en_b = !((k >= 8) && (k <= 12));
      if_b.en = en_b;
      if_d.up_dn = 1'(k % 2);
      if (en_b) e_b++;
      push(0, "a_wrap", k % 256, (k == 256), 1'b0);
      if (k <= 40) begin
        s_b = e_b / 3;
        push(1, "b_down_pre", (10 - (s_b % 10)) % 10, en_b && (e_b % 3 == 0) && (s_b % 10 == 1), 1'b0);
      end
      if (k <= 24) begin
        pos = k % 10;
        push(3, "d_pingpong", (pos <= 5) ? pos : 10 - pos, (pos == 5) || (pos == 0), 1'b0);
      end
      step();
    end

    // C: load clamps to MAX_COUNT, then saturate up and down.
    if_c.load = 1'b1; if_c.load_val = 8'd200;
    push(2, "c_clamp", 100, 1'b0, 1'b0);
    step();
    if_c.load_val = 8'd97;
    push(2, "c_load97", 97, 1'b0, 1'b0);
    step();
    if_c.load = 1'b0; if_c.en = 1'b1; if_c.mode = 2'b01; if_c.up_dn = 1'b1;
    for (int v = 98; v <= 100; v++) begin
      push(2, "c_sat_up", v, (v == 100), (v == 100));
      step();
    end
    for (int i = 0; i < 20; i++) begin
      push(2, "c_sat_hold", 100, 1'b0, 1'b1);
      step();
    end
    if_c.up_dn = 1'b0;
    for (int v = 99; v >= 0; v--) begin
      push(2, "c_sat_down", v, (v == 0), (v == 0));
      step();
    end
    push(2, "c_sat_hold0", 0, 1'b0, 1'b1);
    step();
    if_c.mode = 2'b00; if_c.en = 1'b0;
    push(2, "c_leave_sat", 0, 1'b0, 1'b0);
    step();

    // C: asynchronous reset mid-count, checked before the next clock edge.
    if_c.load = 1'b1; if_c.load_val = 8'd57;
    push(2, "c_load57", 57, 1'b0, 1'b0);
    step();
    if_c.load = 1'b0; if_c.en = 1'b1; if_c.up_dn = 1'b1;
    push(2, "c_run58", 58, 1'b0, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    push(2, "c_async_rst", 0, 1'b0, 1'b0);
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // B: load resets the prescaler phase; load coinciding with a tick wins.
    if_b.en = 1'b1; if_b.mode = 2'b00; if_b.up_dn = 1'b1;
    if_b.load = 1'b1; if_b.load_val = 4'd4;
    push(1, "b_load4", 4, 1'b0, 1'b0);
    step();
    if_b.load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push(1, "b_pre_phase", 4, 1'b0, 1'b0);
      step();
    end
    if_b.load = 1'b1; if_b.load_val = 4'd7;
    push(1, "b_load_vs_tick", 7, 1'b0, 1'b0);
    step();
    if_b.load = 1'b0;
    push(1, "b_after_load", 7, 1'b0, 1'b0);
    step();
    push(1, "b_after_load", 7, 1'b0, 1'b0);
    step();
    push(1, "b_after_load", 8, 1'b0, 1'b0);
    step();

    // A: load held high for 10 cycles.
    if_a.load = 1'b0;
    step();
    if_a.mode = 2'b00; if_a.up_dn = 1'b1; if_a.en = 1'b1;
    if_a.load = 1'b1; if_a.load_val = 8'd3;
    for (int i = 1; i <= 10; i++) begin
`ifdef VIO_COUNTER_LOAD_EDGE_EN
      push(0, "a_load_held", 3 + i - 1, 1'b0, 1'b0);
`else
      push(0, "a_load_held", 3, 1'b0, 1'b0);
`endif
      step();
    end
    if_a.load = 1'b0;
`ifdef VIO_COUNTER_LOAD_EDGE_EN
    push(0, "a_load_release", 13, 1'b0, 1'b0);
`else
    push(0, "a_load_release", 4, 1'b0, 1'b0);
`endif
    step();

    // D: loading MAX_COUNT in ping-pong sets the direction to down.
    if_d.load = 1'b1; if_d.load_val = 8'd5;
    push(3, "d_load_max", 5, 1'b0, 1'b0);
    step();
    if_d.load = 1'b0;
    push(3, "d_after_max", 4, 1'b0, 1'b0);
    step();
    push(3, "d_after_max", 3, 1'b0, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
